// File: rtl/bus_pkg.sv
// Shared bus package.
// Holds the arbiter state encoding and the default bus sizing constants used
// by the bus top level and the testbenches.
package bus_pkg;

  // Arbiter state encoding.
  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT   = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ARB_IDLE,
    ST_GRANT   = ARB_GRANT,
    ST_RELEASE = ARB_RELEASE
  } arb_state_t;

  // Default bus sizing.
  localparam int DEFAULT_NUM_MASTERS    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector upward starting one past the pointer, wrapping
// modulo N, and returns the first requester found.
// Ports:
//   req        in   N   eligible request vector
//   ptr        in   W   index of the previous winner
//   winner     out  N   one-hot winner (all-zero when nothing requests)
//   win_idx    out  W   encoded winner index (0 when nothing requests)
//   any_valid  out  1   at least one request present
module rr_pick
  import bus_pkg::*;
#(
  parameter  int N = DEFAULT_NUM_MASTERS,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] winner,
  output logic [W-1:0] win_idx,
  output logic         any_valid
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  always_comb begin
    logic [W-1:0] cand;
    winner    = '0;
    win_idx   = '0;
    any_valid = 1'b0;
    cand      = ptr;
    // N steps visit every index once, the pointer itself last.
    for (int off = 0; off < N; off++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!any_valid && req[cand]) begin
        any_valid = 1'b1;
        win_idx   = cand;
      end
    end
    if (any_valid) begin
      winner[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system bus arbiter.
// Grants the shared bus to one master for a whole transaction, with a
// watchdog that forcibly revokes a grant held too long and masks the
// offending master until it drops its request.
// Ports:
//   clk          in   1            system clock, rising edge
//   rstn         in   1            asynchronous active-low reset
//   m_req        in   NUM_MASTERS  per-master request, level
//   bus_busy     in   1            slave still completing current transfer
//   m_grant      out  NUM_MASTERS  registered one-hot grant, zero when idle
//   m_sel        out  SEL_WIDTH    granted master index, holds last owner
//   bus_valid    out  1            any grant active
//   timeout_err  out  1            one-cycle pulse on watchdog revoke
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter  int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int SEL_WIDTH      = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic                   bus_busy,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [SEL_WIDTH-1:0]   m_sel,
  output logic                   bus_valid,
  output logic                   timeout_err
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] PTR_RST = SEL_WIDTH'(NUM_MASTERS - 1);

  arb_state_t             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [NUM_MASTERS-1:0] mask_reg, mask_next;
  logic [NUM_MASTERS-1:0] set_mask;
  logic [SEL_WIDTH-1:0]   sel_reg, sel_next;
  logic [SEL_WIDTH-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   timeout_reg, timeout_next;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [SEL_WIDTH-1:0]   pick_idx;
  logic                   pick_valid;
  logic                   owner_req;

  // A master masked by the watchdog stays out of arbitration until it
  // deasserts its request for at least one cycle.
  assign eligible  = m_req & ~mask_reg;
  assign owner_req = |(m_req & grant_reg);

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
      assign mask_next[gi] = m_req[gi] & (mask_reg[gi] | set_mask[gi]);
    end
  endgenerate

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req       (eligible),
    .ptr       (ptr_reg),
    .winner    (pick_onehot),
    .win_idx   (pick_idx),
    .any_valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      mask_reg    <= '0;
      sel_reg     <= '0;
      ptr_reg     <= PTR_RST;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      mask_reg    <= mask_next;
      sel_reg     <= sel_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    sel_next     = sel_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    set_mask     = '0;

    case (state_reg)
      // The turnaround cycle also arbitrates, so back-to-back transactions
      // see exactly one zero-grant cycle between them. The grant that
      // dropped is already zero here, so no overlap is possible.
      ST_IDLE, ST_RELEASE: begin
        cnt_next   = '0;
        grant_next = '0;
        if (pick_valid) begin
          state_next = ST_GRANT;
          grant_next = pick_onehot;
          sel_next   = pick_idx;
          ptr_next   = pick_idx;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (cnt_reg == CNT_LAST) begin
          // Watchdog revoke wins over everything, including bus_busy.
          state_next   = ST_RELEASE;
          grant_next   = '0;
          cnt_next     = '0;
          timeout_next = 1'b1;
          set_mask     = grant_reg;
        end else if (!owner_req && !bus_busy) begin
          state_next = ST_RELEASE;
          grant_next = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign m_grant     = grant_reg;
  assign m_sel       = sel_reg;
  assign bus_valid   = |grant_reg;
  assign timeout_err = timeout_reg;

endmodule
